// File: rtl/axi_slave_mem.sv
// AXI3 slave scratch memory: byte-enabled word array with independent
// single-outstanding write and read state machines.
module axi_slave_mem #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic [1:0]        AWLOCK,
  input  logic [3:0]        AWCACHE,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ID_W-1:0]   WID,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic [1:0]        ARLOCK,
  input  logic [3:0]        ARCACHE,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int unsigned      IDX_W       = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] MEM_BYTES  = ADDR_W'(4 * MEM_WORDS);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Lock/cache/prot carry no meaning for a plain memory target.
  logic unused_ok;
  assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

  // Next beat address for FIXED / INCR / WRAP; odd WRAP lengths and 2'b11 act as INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [3:0] len,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] cont;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] nxt;
    logic              wrap_len;
    inc      = ADDR_W'(1) << size;
    cont     = (ADDR_W'(len) + ADDR_W'(1)) << size;
    base     = addr & ~(cont - ADDR_W'(1));
    nxt      = addr + inc;
    wrap_len = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    if (burst == 2'b00)
      next_addr = addr;
    else if ((burst == 2'b10) && wrap_len && (nxt == base + cont))
      next_addr = base;
    else
      next_addr = nxt;
  endfunction

  // ---------------- write path ----------------
  logic [1:0]        w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_len;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [3:0]        w_cnt;
  logic              w_err;
  logic              w_fire, w_last_beat, w_range_err, w_beat_err, w_we;

  assign w_fire      = WVALID & WREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign w_range_err = (w_addr >= MEM_BYTES);
  assign w_beat_err  = w_range_err | (w_size > 3'd2) | (WID != w_id) | (WLAST != w_last_beat);
  assign w_we        = w_fire & ~w_range_err & ~(w_size > 3'd2);

  // Write state transitions.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (AWVALID && AWREADY) w_next = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_next = W_RESP;
      W_RESP:  if (BVALID && BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, burst context and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      AWREADY <= (w_next == W_IDLE);
      WREADY  <= (w_next == W_DATA);
      BVALID  <= (w_next == W_RESP);
      if ((w_state == W_IDLE) && AWVALID && AWREADY) begin
        w_id    <= AWID;
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_size  <= AWSIZE;
        w_burst <= AWBURST;
        w_cnt   <= 4'd0;
        w_err   <= 1'b0;
      end else if (w_fire) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 4'd1;
        w_err  <= w_err | w_beat_err;
        if (w_last_beat) begin
          BID   <= w_id;
          BRESP <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-lane writes; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (WSTRB[i]) mem[w_addr[IDX_W+1:2]][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic [0:0]        r_state, r_next;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_next_addr, rd_addr;
  logic              rd_size_err, rd_last, rd_err, r_load_first, r_load_next;
  logic [DATA_W-1:0] rd_word;

  assign r_next_addr  = next_addr(r_addr, r_len, r_size, r_burst);
  assign r_load_first = (r_state == R_IDLE) & ARVALID & ARREADY;
  assign r_load_next  = (r_state == R_DATA) & RVALID & RREADY & ~RLAST;

  // Select the beat to fetch: first beat from AR, later beats from the running address.
  always_comb begin
    rd_addr     = r_next_addr;
    rd_size_err = (r_size > 3'd2);
    rd_last     = ((r_cnt + 4'd1) == r_len);
    if (r_state == R_IDLE) begin
      rd_addr     = ARADDR;
      rd_size_err = (ARSIZE > 3'd2);
      rd_last     = (ARLEN == 4'd0);
    end
  end

  assign rd_err  = rd_size_err | (rd_addr >= MEM_BYTES);
  assign rd_word = mem[rd_addr[IDX_W+1:2]];

  // Read state transitions.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ARVALID && ARREADY) r_next = R_DATA;
      R_DATA:  if (RVALID && RREADY && RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read state, burst context and registered beat outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
      RLAST   <= 1'b0;
    end else begin
      r_state <= r_next;
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_DATA);
      if (r_load_first) begin
        RID     <= ARID;
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= ARBURST;
        r_cnt   <= 4'd0;
      end else if (r_load_next) begin
        r_addr <= r_next_addr;
        r_cnt  <= r_cnt + 4'd1;
      end
      if (r_load_first || r_load_next) begin
        RDATA <= rd_err ? '0 : rd_word;
        RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
        RLAST <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem against a byte-array reference model.
module tb_axi_slave_mem;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned MEM_BYTES = 4 * MEM_WORDS;

  logic        clk, rst;
  logic [3:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB, AWCACHE, ARCACHE;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [MEM_BYTES];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  logic [3:0]  wi [16];

  axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Address of beat k from the burst rules, computed arithmetically.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int k);
    logic [31:0] bytes, cont, base;
    bytes = 32'd1 << size;
    if (burst == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      cont = 32'(len + 1) * bytes;
      base = a - (a % cont);
      return base + ((a - base + 32'(k) * bytes) % cont);
    end
    return a + 32'(k) * bytes;
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [31:0] a, input int len, input int size,
                                           input int burst, input logic [3:0] id);
    bit err;
    err = (size > 2);
    for (int k = 0; k <= len; k++) begin
      if (beat_addr(a, len, size, burst, k) >= MEM_BYTES) err = 1;
      if (wi[k] != id) err = 1;
      if (wl[k] != (k == len)) err = 1;
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'd3;
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  task automatic fill_beats(input int len, input logic [3:0] id);
    for (int k = 0; k < 16; k++) begin
      wd[k] = $urandom;
      ws[k] = 4'hF;
      wi[k] = id;
      wl[k] = (k == len);
    end
  endtask

  // Full write transaction; returns observed response and latency samples.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int bdelay,
                          output logic [1:0] bresp, output logic [3:0] bid,
                          output logic wready_lat, output logic bvalid_lat);
    int n;
    logic [31:0] a;
    @(negedge clk);
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
    AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; errors++; $display("FAIL aw_timeout awready=%b", AWREADY); end
    @(negedge clk);
    AWVALID = 1'b0;
    wready_lat = WREADY;
    for (int k = 0; k <= len; k++) begin
      WID = wi[k]; WDATA = wd[k]; WSTRB = ws[k]; WLAST = wl[k]; WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin checks++; errors++; $display("FAIL w_timeout beat=%0d", k); end
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    bvalid_lat = BVALID;
    repeat (bdelay) @(negedge clk);
    BREADY = 1'b1;
    n = 0;
    while (BVALID !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; errors++; $display("FAIL b_timeout bvalid=%b", BVALID); end
    bresp = BRESP; bid = BID;
    @(negedge clk);
    BREADY = 1'b0;
    if (size <= 2) begin
      for (int k = 0; k <= len; k++) begin
        a = beat_addr(addr, len, size, burst, k);
        if (a < MEM_BYTES)
          for (int i = 0; i < 4; i++)
            if (ws[k][i]) mm[(a & ~32'd3) + 32'(i)] = wd[k][8*i +: 8];
      end
    end
  endtask

  // Full read transaction, comparing every presented beat with the model.
  // mode 0: RREADY always 1, 1: toggles 1,0,1,0..., 2: random.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input int mode);
    int n, k, cyc;
    bit tog, hs;
    logic [31:0] a, ed;
    logic [1:0]  er;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
    ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; errors++; $display("FAIL ar_timeout arready=%b", ARREADY); end
    @(negedge clk);
    ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1) begin errors++; $display("FAIL r_first_latency rvalid=%b exp=1", RVALID); end
    k = 0; cyc = 0; tog = 1'b1;
    while (k <= len && cyc < 400) begin
      RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom % 2);
      tog = ~tog;
      a = beat_addr(addr, len, size, burst, k);
      if (size > 2 || a >= MEM_BYTES) begin ed = 32'h0; er = 2'b10; end
      else begin ed = model_word(a); er = 2'b00; end
      checks++;
      if ({RVALID, RID, RDATA, RRESP, RLAST} !== {1'b1, id, ed, er, 1'(k == len)}) begin
        errors++;
        $display("FAIL r_beat%0d addr=%h got v=%b id=%h d=%h r=%b l=%b exp v=1 id=%h d=%h r=%b l=%b",
                 k, a, RVALID, RID, RDATA, RRESP, RLAST, id, ed, er, (k == len));
      end
      hs = RREADY & RVALID;
      @(negedge clk);
      cyc++;
      if (hs) k++;
    end
    RREADY = 1'b0;
    checks++;
    if (cyc >= 400 || RVALID !== 1'b0) begin
      errors++; $display("FAIL r_end rvalid=%b cycles=%0d exp rvalid=0", RVALID, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
      errors++;
      $display("FAIL reset_outputs aw=%b w=%b b=%b ar=%b r=%b rdata=%h exp all 0",
               AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_release got aw/ar/w/b/r=%b%b%b%b%b exp 11000",
               AWREADY, ARREADY, WREADY, BVALID, RVALID);
    end
  endtask

  task automatic test_single();
    logic [1:0] br; logic [3:0] bi; logic wl_lat, bv_lat;
    fill_beats(0, 4'h3);
    wd[0] = 32'hDEADBEEF;
    do_write(4'h3, 32'h10, 0, 2, 1, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if ({wl_lat, bv_lat} !== 2'b11) begin
      errors++; $display("FAIL single_latency wready=%b bvalid=%b exp 1 1", wl_lat, bv_lat);
    end
    checks++;
    if ({br, bi} !== {2'b00, 4'h3}) begin
      errors++; $display("FAIL single_bresp got resp=%b id=%h exp resp=00 id=3", br, bi);
    end
    checks++;
    if (model_word(32'h10) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_model got=%h exp=deadbeef", model_word(32'h10));
    end
    do_read(4'h5, 32'h10, 0, 2, 1, 0);
  endtask

  task automatic test_incr_stall();
    logic [1:0] br; logic [3:0] bi; logic wl_lat, bv_lat;
    fill_beats(3, 4'h1);
    for (int k = 0; k < 4; k++) wd[k] = 32'(k + 1);
    do_write(4'h1, 32'h100, 3, 2, 1, 2, br, bi, wl_lat, bv_lat);
    checks++;
    if ({br, bi} !== {2'b00, 4'h1}) begin
      errors++; $display("FAIL incr_bresp got resp=%b id=%h exp resp=00 id=1", br, bi);
    end
    do_read(4'h2, 32'h100, 3, 2, 1, 1);
  endtask

  task automatic test_wrap();
    logic [1:0] br; logic [3:0] bi; logic wl_lat, bv_lat;
    fill_beats(3, 4'h6);
    for (int k = 0; k < 4; k++) wd[k] = 32'(k + 1);
    do_write(4'h6, 32'h108, 3, 2, 2, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if ({model_word(32'h100), model_word(32'h10C), br} !== {32'd3, 32'd2, 2'b00}) begin
      errors++; $display("FAIL wrap_model got w100=%h w10c=%h resp=%b exp 3 2 00",
                         model_word(32'h100), model_word(32'h10C), br);
    end
    do_read(4'h7, 32'h100, 3, 2, 1, 0);
    do_read(4'h8, 32'h108, 3, 2, 2, 2);
  endtask

  task automatic test_strobe();
    logic [1:0] br; logic [3:0] bi; logic wl_lat, bv_lat;
    fill_beats(0, 4'h2);
    wd[0] = 32'h0;
    do_write(4'h2, 32'h20, 0, 2, 1, 0, br, bi, wl_lat, bv_lat);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    do_write(4'h2, 32'h20, 0, 2, 1, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if (model_word(32'h20) !== 32'h00BB00DD) begin
      errors++; $display("FAIL strobe_model got=%h exp=00bb00dd", model_word(32'h20));
    end
    do_read(4'h4, 32'h20, 0, 2, 1, 0);
  endtask

  task automatic test_errors();
    logic [1:0] br; logic [3:0] bi; logic wl_lat, bv_lat;
    // Out-of-range write must leave the aliasing low word untouched.
    fill_beats(0, 4'h1); wd[0] = 32'h12345678;
    do_write(4'h1, 32'h0, 0, 2, 1, 0, br, bi, wl_lat, bv_lat);
    fill_beats(0, 4'h9); wd[0] = 32'hFFFF0000;
    do_write(4'h9, 32'(MEM_BYTES), 0, 2, 1, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if ({br, bi} !== {2'b10, 4'h9}) begin
      errors++; $display("FAIL err_range_bresp got resp=%b id=%h exp resp=10 id=9", br, bi);
    end
    do_read(4'h1, 32'h0, 0, 2, 1, 0);
    // Early WLAST: all four beats accepted and written, SLVERR returned.
    fill_beats(3, 4'hA); wl[1] = 1'b1;
    do_write(4'hA, 32'h300, 3, 2, 1, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if (br !== exp_bresp(32'h300, 3, 2, 1, 4'hA) || br !== 2'b10) begin
      errors++; $display("FAIL err_wlast_bresp got=%b exp=10", br);
    end
    do_read(4'hA, 32'h300, 3, 2, 1, 0);
    // WID mismatch on one beat.
    fill_beats(1, 4'hB); wi[1] = 4'hC;
    do_write(4'hB, 32'h340, 1, 2, 1, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if (br !== 2'b10) begin errors++; $display("FAIL err_wid_bresp got=%b exp=10", br); end
    // Oversize write: accepted, nothing written.
    fill_beats(0, 4'hD); wd[0] = 32'h0BADF00D;
    do_write(4'hD, 32'h40, 0, 2, 1, 0, br, bi, wl_lat, bv_lat);
    fill_beats(0, 4'hD); wd[0] = 32'h55555555;
    do_write(4'hD, 32'h40, 0, 3, 1, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if (br !== 2'b10) begin errors++; $display("FAIL err_awsize_bresp got=%b exp=10", br); end
    do_read(4'hD, 32'h40, 0, 2, 1, 0);
    // Burst crossing the top of memory: first two beats land, last two error.
    fill_beats(3, 4'hE);
    do_write(4'hE, 32'(MEM_BYTES - 8), 3, 2, 1, 0, br, bi, wl_lat, bv_lat);
    checks++;
    if (br !== 2'b10) begin errors++; $display("FAIL err_cross_bresp got=%b exp=10", br); end
    do_read(4'hE, 32'(MEM_BYTES - 8), 3, 2, 1, 2);
    // Oversize read.
    do_read(4'hF, 32'h10, 0, 3, 1, 0);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    fill_beats(7, 4'h5);
    @(negedge clk);
    AWID = 4'h5; AWADDR = 32'h200; AWLEN = 4'd7; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    AWVALID = 1'b0;
    for (int k = 0; k < 2; k++) begin
      WID = 4'h5; WDATA = wd[k]; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      mm[32'h200 + 4*k + 0] = wd[k][7:0];   mm[32'h200 + 4*k + 1] = wd[k][15:8];
      mm[32'h200 + 4*k + 2] = wd[k][23:16]; mm[32'h200 + 4*k + 3] = wd[k][31:24];
    end
    WVALID = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
      errors++; $display("FAIL midburst_reset_outputs aw=%b w=%b b=%b ar=%b r=%b exp all 0",
                         AWREADY, WREADY, BVALID, ARREADY, RVALID);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({AWREADY, WREADY} !== 2'b10) begin
      errors++; $display("FAIL midburst_release aw=%b w=%b exp 1 0", AWREADY, WREADY);
    end
    n = 0;
    repeat (10) begin @(negedge clk); if (BVALID !== 1'b0) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL midburst_bvalid high_cycles=%0d exp 0", n); end
    do_read(4'h5, 32'h200, 1, 2, 1, 0);
  endtask

  task automatic test_random();
    logic [1:0] br; logic [3:0] bi; logic wl_lat, bv_lat;
    logic [31:0] addr;
    int len, size, burst;
    logic [3:0] id;
    for (int b = 0; b < 20; b++) begin
      fill_beats(15, 4'h0);
      do_write(4'h0, 32'(b * 64), 15, 2, 1, 0, br, bi, wl_lat, bv_lat);
    end
    for (int t = 0; t < 30; t++) begin
      id = 4'($urandom);
      len = int'($urandom_range(0, 15));
      size = int'($urandom_range(0, 2));
      burst = int'($urandom_range(0, 3));
      addr = $urandom_range(0, 32'h3FF) & ~((32'd1 << size) - 1);
      fill_beats(len, id);
      for (int k = 0; k <= len; k++) ws[k] = 4'($urandom);
      do_write(id, addr, len, size, burst, int'($urandom_range(0, 2)), br, bi, wl_lat, bv_lat);
      checks++;
      if ({br, bi} !== {exp_bresp(addr, len, size, burst, id), id}) begin
        errors++; $display("FAIL rand_bresp t=%0d got resp=%b id=%h exp resp=%b id=%h",
                           t, br, bi, exp_bresp(addr, len, size, burst, id), id);
      end
      do_read(4'(id + 1), addr, len, size, burst, 2);
      do_read(4'($urandom), $urandom_range(0, 32'h3FC) & ~32'd3, int'($urandom_range(0, 15)),
              2, int'($urandom_range(0, 3)), 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID} = '0;
    {WID, WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY} = '0;
    test_reset();
    test_single();
    test_incr_stall();
    test_wrap();
    test_strobe();
    test_errors();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
